// File: rtl/uart_rx_fifo_pkg.sv
// Shared definitions for the UART receive path: default line timing, ack FSM states
// and the idle-timeout length helper (used when UART_RX_TIMEOUT_EN is defined).
package uart_rx_fifo_pkg;

  localparam int unsigned DEF_CLK   = 28000000;
  localparam int unsigned DEF_BPS   = 115200;
  localparam int unsigned TMO_CHARS = 4;
  localparam int unsigned TMO_BITS  = 10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ACK  = 1'b1
  } ack_state_e;

  // Idle time of TMO_CHARS character frames, in clock cycles.
  function automatic int unsigned tmo_cycles(input int unsigned clk_hz, input int unsigned bps);
    longint unsigned t;
    t = longint'(TMO_CHARS * TMO_BITS) * longint'(clk_hz) / longint'(bps);
    return int'(t);
  endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// DEPTH x W storage with a synchronous write port and a registered read port;
// a same-cycle write to the address being read is forwarded to the read data.
module sync_fifo_ram #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4,
  parameter int unsigned W     = 8
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [W-1:0]  rdata_o
);

  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (we_i && (waddr_i == raddr_i)) rdata_q <= wdata_i;
    else                              rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive buffer: acks each received byte, stores it in a FWFT FIFO, drives
// hysteretic rx_hold and sticky overrun. Optional idle timeout: UART_RX_TIMEOUT_EN.
module uart_rx_fifo
  import uart_rx_fifo_pkg::*;
#(
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned AW          = 4,
  parameter int unsigned HOLD_MARGIN = 4,
  parameter int unsigned CLK         = DEF_CLK,
  parameter int unsigned BPS         = DEF_BPS
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    rxdata,
  input  logic          rxrecv,
  output logic          data_read,
  input  logic          cpu_rd,
  output logic [7:0]    cpu_dout,
  output logic          fifo_empty,
  output logic          fifo_full,
  output logic [AW:0]   level,
  output logic          overrun,
  input  logic          overrun_clr,
`ifdef UART_RX_TIMEOUT_EN
  output logic          rx_timeout,
`endif
  output logic          rx_hold
);

  localparam logic [AW:0] FULL_LV  = (AW+1)'(DEPTH);
  localparam logic [AW:0] HOLD_ON  = (AW+1)'(DEPTH - HOLD_MARGIN);
  localparam logic [AW:0] HOLD_OFF = (AW+1)'(DEPTH / 2);

  if (DEPTH < 4 || (32'd1 << AW) != DEPTH || HOLD_MARGIN >= DEPTH / 2 || BPS == 0 || CLK < BPS) begin : g_cfg_check
    $error("uart_rx_fifo: inconsistent DEPTH/AW/HOLD_MARGIN/CLK/BPS");
  end

  ack_state_e    state_q, state_d;
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]   level_q, level_d;
  logic          ovr_q, ovr_d;
  logic          hold_q, hold_d;
  logic          do_push, do_pop, drop;
  logic [7:0]    ram_rdata;

  always_comb begin
    do_pop  = cpu_rd && (level_q != '0);
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the byte.
    do_push = rxrecv && ((level_q != FULL_LV) || do_pop);
    drop    = rxrecv && !do_push;

    wptr_d  = do_push ? wptr_q + 1'b1 : wptr_q;
    rptr_d  = do_pop  ? rptr_q + 1'b1 : rptr_q;
    level_d = level_q;
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase

    ovr_d = drop ? 1'b1 : (overrun_clr ? 1'b0 : ovr_q);

    hold_d = hold_q;
    if (level_d >= HOLD_ON)       hold_d = 1'b1;
    else if (level_d <= HOLD_OFF) hold_d = 1'b0;

    state_d = state_q;
    case (state_q)
      ST_IDLE: state_d = rxrecv ? ST_ACK : ST_IDLE;
      ST_ACK:  state_d = rxrecv ? ST_ACK : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      ovr_q   <= 1'b0;
      hold_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
      ovr_q   <= ovr_d;
      hold_q  <= hold_d;
    end
  end

  // Read port addressed by the next read pointer so the head is ready one cycle later.
  sync_fifo_ram #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .W     (8)
  ) u_ram (
    .clk     (clk),
    .we_i    (do_push),
    .waddr_i (wptr_q),
    .wdata_i (rxdata),
    .raddr_i (rptr_d),
    .rdata_o (ram_rdata)
  );

  assign data_read  = (state_q == ST_ACK);
  assign fifo_empty = (level_q == '0);
  assign fifo_full  = (level_q == FULL_LV);
  assign level      = level_q;
  assign overrun    = ovr_q;
  assign rx_hold    = hold_q;
  assign cpu_dout   = fifo_empty ? 8'h00 : ram_rdata;

`ifdef UART_RX_TIMEOUT_EN
  localparam logic [19:0] TMO = 20'(tmo_cycles(CLK, BPS));

  logic [19:0] tcnt_q, tcnt_d;
  logic        tmo_q, tmo_d;

  always_comb begin
    tcnt_d = tcnt_q;
    tmo_d  = tmo_q;
    if (do_push || do_pop) begin
      tcnt_d = '0;
      tmo_d  = 1'b0;
    end else if (level_q != '0 && !tmo_q) begin
      tcnt_d = tcnt_q + 1'b1;
      if (tcnt_d == TMO) tmo_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tcnt_q <= '0;
      tmo_q  <= 1'b0;
    end else begin
      tcnt_q <= tcnt_d;
      tmo_q  <= tmo_d;
    end
  end

  assign rx_timeout = tmo_q;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: directed scenarios plus random traffic
// compared against a queue-based model of the receive buffer.
module tb_uart_rx_fifo;

  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rxdata = 8'h00;
  logic       rxrecv = 1'b0;
  logic       cpu_rd = 1'b0;
  logic       overrun_clr = 1'b0;
  logic       data_read;
  logic [7:0] cpu_dout;
  logic       fifo_empty, fifo_full, overrun, rx_hold;
  logic [4:0] level;
`ifdef UART_RX_TIMEOUT_EN
  logic       rx_timeout;
`endif

  uart_rx_fifo #(
    .DEPTH       (16),
    .AW          (4),
    .HOLD_MARGIN (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rxdata      (rxdata),
    .rxrecv      (rxrecv),
    .data_read   (data_read),
    .cpu_rd      (cpu_rd),
    .cpu_dout    (cpu_dout),
    .fifo_empty  (fifo_empty),
    .fifo_full   (fifo_full),
    .level       (level),
    .overrun     (overrun),
    .overrun_clr (overrun_clr),
`ifdef UART_RX_TIMEOUT_EN
    .rx_timeout  (rx_timeout),
`endif
    .rx_hold     (rx_hold)
  );

  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;

  byte unsigned q[$];
  bit m_ovr = 1'b0;
  bit m_hold = 1'b0;
  bit m_dr = 1'b0;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".level"}, {3'b000, level}, 8'(q.size()));
    chk({tag, ".empty"}, {7'd0, fifo_empty}, {7'd0, q.size() == 0});
    chk({tag, ".full"}, {7'd0, fifo_full}, {7'd0, q.size() == DEPTH});
    chk({tag, ".dout"}, cpu_dout, (q.size() > 0) ? q[0] : 8'h00);
    chk({tag, ".data_read"}, {7'd0, data_read}, {7'd0, m_dr});
    chk({tag, ".overrun"}, {7'd0, overrun}, {7'd0, m_ovr});
    chk({tag, ".rx_hold"}, {7'd0, rx_hold}, {7'd0, m_hold});
  endtask

  // One clock: drive inputs, advance the model by the intended behaviour, sample #1 after the edge.
  task automatic cycle(input bit rv, input byte unsigned d, input bit rd, input bit clr);
    bit was_full, popped, dropped;
    rxrecv = rv; rxdata = d; cpu_rd = rd; overrun_clr = clr;
    was_full = (q.size() == DEPTH);
    popped = rd && (q.size() > 0);
    dropped = 1'b0;
    if (popped) void'(q.pop_front());
    if (rv) begin
      if (!was_full || popped) q.push_back(d);
      else dropped = 1'b1;
    end
    if (dropped) m_ovr = 1'b1;
    else if (clr) m_ovr = 1'b0;
    if (q.size() >= DEPTH - 4) m_hold = 1'b1;
    else if (q.size() <= DEPTH / 2) m_hold = 1'b0;
    m_dr = rv;
    @(posedge clk);
    #1;
    rxrecv = 1'b0; cpu_rd = 1'b0; overrun_clr = 1'b0;
  endtask

  task automatic do_reset(input bit rv);
    rst = 1'b1; rxrecv = rv; rxdata = 8'h5A;
    @(posedge clk);
    #1;
    rst = 1'b0; rxrecv = 1'b0;
    q.delete(); m_ovr = 1'b0; m_hold = 1'b0; m_dr = 1'b0;
  endtask

  initial begin
    do_reset(1'b0);
    check_all("reset");

    cycle(1, 8'hA5, 0, 0); check_all("a5_write");
    cycle(0, 8'h00, 0, 0); check_all("a5_idle");
    cycle(0, 8'h00, 1, 0); check_all("a5_pop");

    for (int i = 0; i < DEPTH; i++) begin
      cycle(1, 8'(i), 0, 0); check_all("fill");
    end
    cycle(1, 8'hFF, 0, 0); check_all("overflow");
    cycle(0, 8'h00, 0, 0); check_all("overflow_idle");
    for (int i = 0; i < DEPTH; i++) begin
      chk("drain_order", cpu_dout, 8'(i));
      cycle(0, 8'h00, 1, 0); check_all("drain");
    end
    cycle(0, 8'h00, 0, 1); check_all("ovr_clear");

    for (int i = 0; i < DEPTH; i++) cycle(1, 8'(8'h40 + i), 0, 0);
    check_all("refill");
    cycle(1, 8'h77, 1, 0); check_all("full_wr_rd");
    cycle(1, 8'h78, 0, 1); check_all("set_beats_clear");
    cycle(0, 8'h00, 0, 1); check_all("clear_again");
    while (q.size() > 0) begin
      cycle(0, 8'h00, 1, 0); check_all("drain2");
    end

    cycle(1, 8'h3C, 1, 0); check_all("empty_wr_rd");
    cycle(0, 8'h00, 1, 0); check_all("pop_last");
    cycle(0, 8'h00, 1, 0); check_all("pop_empty");

    for (int i = 0; i < 6; i++) cycle(1, 8'($urandom), 0, 0);
    for (int i = 0; i < 20; i++) begin
      cycle(1, 8'($urandom), 1, 0); check_all("wrap");
    end

    while (q.size() > 5) cycle(0, 8'h00, 1, 0);
    while (q.size() < 5) cycle(1, 8'($urandom), 0, 0);
    cycle(1, 8'hEE, 0, 0);
    cycle(1, 8'hEF, 0, 0);
    for (int i = 0; i < 12; i++) cycle(1, 8'($urandom), 0, 0);
    while (q.size() > 5) cycle(0, 8'h00, 1, 0);
    check_all("pre_reset");
    do_reset(1'b1);
    check_all("mid_reset");

    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 99) < 55, 8'($urandom), $urandom_range(0, 99) < 45,
            $urandom_range(0, 99) < 5);
      check_all("random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
